pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core (F, D, E, M, W). It consumes the stall request from the hazard detection unit together with branch, multi-cycle multiply and memory-ready events. From these it drives the enable and bubble controls of every stage register and selects the PC source. It also owns the multiply-occupancy FSM and the stall and flush performance counters.

---
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: stage enables/bubbles,
// PC source select, multiply-occupancy FSM and saturating stall/flush counters.
module pipe_ctrl #(
    parameter int MUL_LAT   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_haz_nop,
    input  logic                 i_mul_e,
    input  logic                 i_branch_e,
    input  logic                 i_dmem_req_m,
    input  logic                 i_dmem_ready,
    input  logic                 i_imem_ready,
    output logic                 o_en_pc,
    output logic                 o_en_fd,
    output logic                 o_en_de,
    output logic                 o_en_em,
    output logic                 o_en_mw,
    output logic                 o_bubble_fd,
    output logic                 o_bubble_de,
    output logic                 o_bubble_em,
    output logic                 o_bubble_mw,
    output logic                 o_pc_sel,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_MUL = 1'b1} state_t;

    // The first stall cycle happens in RUN, the release cycle in MUL, hence the -2.
    localparam logic           MUL_MULTI = (MUL_LAT > 1);
    localparam logic [7:0]     MUL_LOAD  = (MUL_LAT > 1) ? 8'(MUL_LAT - 2) : 8'd0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [CNT_WIDTH-1:0]  flush_q, flush_d;
    logic                  mem_stall_s;
    logic                  mul_stall_s;
    logic                  branch_act_s;

    assign mem_stall_s = i_dmem_req_m & ~i_dmem_ready;
    assign mul_stall_s = ((state_q == ST_RUN) & i_mul_e & MUL_MULTI) |
                         ((state_q == ST_MUL) & (cnt_q != 8'd0));

    // Stage control decode, first matching condition wins
    always_comb begin
        o_en_pc      = 1'b1;
        o_en_fd      = 1'b1;
        o_en_de      = 1'b1;
        o_en_em      = 1'b1;
        o_en_mw      = 1'b1;
        o_bubble_fd  = 1'b0;
        o_bubble_de  = 1'b0;
        o_bubble_em  = 1'b0;
        o_bubble_mw  = 1'b0;
        o_pc_sel     = 1'b0;
        branch_act_s = 1'b0;
        if (i_rst) begin
            o_en_pc = 1'b0;
            o_en_fd = 1'b0;
            o_en_de = 1'b0;
            o_en_em = 1'b0;
            o_en_mw = 1'b0;
        end else if (mem_stall_s) begin
            o_en_pc     = 1'b0;
            o_en_fd     = 1'b0;
            o_en_de     = 1'b0;
            o_en_em     = 1'b0;
            o_bubble_mw = 1'b1;
        end else if (mul_stall_s) begin
            o_en_pc     = 1'b0;
            o_en_fd     = 1'b0;
            o_en_de     = 1'b0;
            o_bubble_em = 1'b1;
        end else if (i_branch_e) begin
            o_pc_sel     = 1'b1;
            o_bubble_fd  = 1'b1;
            o_bubble_de  = 1'b1;
            branch_act_s = 1'b1;
        end else if (i_haz_nop) begin
            o_en_pc     = 1'b0;
            o_en_fd     = 1'b0;
            o_bubble_de = 1'b1;
        end else if (!i_imem_ready) begin
            o_en_pc     = 1'b0;
            o_bubble_fd = 1'b1;
        end else begin
            o_pc_sel = 1'b0;
        end
    end

    // Multiply-occupancy next state; a memory stall freezes everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_stall_s) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_mul_e && MUL_MULTI) begin
                        state_d = ST_MUL;
                        cnt_d   = MUL_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MUL: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Saturating performance counter next values
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!o_en_pc && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        if (branch_act_s && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_ONE;
        end else begin
            flush_d = flush_q;
        end
    end

    // State and counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 8'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign o_busy      = (state_q == ST_MUL);
    assign o_stall_cnt = stall_q;
    assign o_flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected stage controls queued per cycle,
// counters tracked by a bench-side model; a second MUL_LAT=1/CNT_WIDTH=4 copy.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [4:0] en;   // pc, fd, de, em, mw
        logic [3:0] bub;  // fd, de, em, mw
        logic       sel;
    } ctl_t;

    localparam ctl_t C_RST  = ctl_t'{5'b00000, 4'b0000, 1'b0};
    localparam ctl_t C_NORM = ctl_t'{5'b11111, 4'b0000, 1'b0};
    localparam ctl_t C_MEM  = ctl_t'{5'b00001, 4'b0001, 1'b0};
    localparam ctl_t C_MULS = ctl_t'{5'b00011, 4'b0010, 1'b0};
    localparam ctl_t C_BR   = ctl_t'{5'b11111, 4'b1100, 1'b1};
    localparam ctl_t C_HAZ  = ctl_t'{5'b00111, 4'b0100, 1'b0};
    localparam ctl_t C_FW   = ctl_t'{5'b01111, 4'b1000, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mul, br, haz, req, rdy, imr;
    logic en_pc, en_fd, en_de, en_em, en_mw, b_fd, b_de, b_em, b_mw, pc_sel, busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_en_pc, s_en_fd, s_en_de, s_en_em, s_en_mw, s_b_fd, s_b_de, s_b_em, s_b_mw, s_pc_sel, s_busy;
    logic [3:0] s_stall_cnt, s_flush_cnt;
    ctl_t obs_s;

    assign obs_s = {en_pc, en_fd, en_de, en_em, en_mw, b_fd, b_de, b_em, b_mw, pc_sel};

    pipe_ctrl #(.MUL_LAT(4), .CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_haz_nop(haz), .i_mul_e(mul), .i_branch_e(br),
        .i_dmem_req_m(req), .i_dmem_ready(rdy), .i_imem_ready(imr),
        .o_en_pc(en_pc), .o_en_fd(en_fd), .o_en_de(en_de), .o_en_em(en_em), .o_en_mw(en_mw),
        .o_bubble_fd(b_fd), .o_bubble_de(b_de), .o_bubble_em(b_em), .o_bubble_mw(b_mw),
        .o_pc_sel(pc_sel), .o_busy(busy), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.MUL_LAT(1), .CNT_WIDTH(4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_haz_nop(haz), .i_mul_e(mul), .i_branch_e(br),
        .i_dmem_req_m(req), .i_dmem_ready(rdy), .i_imem_ready(imr),
        .o_en_pc(s_en_pc), .o_en_fd(s_en_fd), .o_en_de(s_en_de), .o_en_em(s_en_em), .o_en_mw(s_en_mw),
        .o_bubble_fd(s_b_fd), .o_bubble_de(s_b_de), .o_bubble_em(s_b_em), .o_bubble_mw(s_b_mw),
        .o_pc_sel(s_pc_sel), .o_busy(s_busy), .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
    );

    ctl_t exp_q[$];
    int errs = 0;
    int checks = 0;
    int stall_m = 0;
    int flush_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, queue expectation, compare controls mid-cycle,
    // then compare counters just after the edge. busy_e/spc_e of 2 = not checked.
    task automatic cyc(input string tag, input logic m, input logic b, input logic h,
                       input logic rq, input logic rd, input logic im,
                       input ctl_t e, input int busy_e, input int spc_e);
        ctl_t x;
        @(negedge clk);
        mul = m; br = b; haz = h; req = rq; rdy = rd; imr = im;
        exp_q.push_back(e);
        #1;
        x = exp_q.pop_front();
        chk({tag, "/ctl"}, 32'(obs_s), 32'(x));
        if (busy_e != 2) chk({tag, "/busy"}, 32'(busy), 32'(busy_e));
        if (spc_e != 2) chk({tag, "/s_en_pc"}, 32'(s_en_pc), 32'(spc_e));
        if (!x.en[4]) stall_m++;
        if (x.sel) flush_m++;
        @(posedge clk);
        #1;
        chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
        chk({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
    endtask

    initial begin
        rst = 1'b1; mul = 1'b0; br = 1'b0; haz = 1'b0; req = 1'b0; rdy = 1'b0; imr = 1'b1;
        #12;
        chk("rst/ctl", 32'(obs_s), 32'(C_RST));
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst/flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        cyc("idle",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 1);
        // MUL_LAT=4 multiply: three stall cycles, release on the fourth
        cyc("mul1",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 0, 1);
        cyc("mul2",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 1, 1);
        cyc("mul3",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 1, 1);
        cyc("mul4",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 2, 1);
        cyc("mulx",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 1);
        // multiply with a two-cycle memory stall at cycle 2
        cyc("mm1",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 0, 1);
        cyc("mm2",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_MEM,  1, 0);
        cyc("mm3",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_MEM,  1, 0);
        cyc("mm4",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 1, 1);
        cyc("mm5",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 1, 1);
        cyc("mm6",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 2, 1);
        cyc("mmx",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 1);
        // priority corners
        cyc("memBr",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_MEM,  0, 0);
        cyc("brAll",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_BR,   0, 1);
        cyc("haz",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_HAZ,  0, 0);
        cyc("fwait",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FW,   0, 0);
        cyc("memRdy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_NORM, 0, 1);
        // hazard held through a multiply takes effect at release
        cyc("mh1",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_MULS, 0, 0);
        cyc("mh2",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_MULS, 1, 0);
        cyc("mh3",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_MULS, 1, 0);
        cyc("mh4",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_HAZ,  2, 0);
        cyc("mhx",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 1);
        // branch at multiply start is ignored, branch at release is taken
        cyc("mb1",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 0, 1);
        cyc("mb2",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 1, 1);
        cyc("mb3",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 1, 1);
        cyc("mb4",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_BR,   2, 1);
        cyc("mbx",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 1);

        // 20 fetch-wait cycles: the 4-bit counter must saturate and hold
        for (int i = 0; i < 20; i++) begin
            cyc("sat", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FW, 0, 0);
            if (i >= 14) chk("sat/s_stall_cnt", 32'(s_stall_cnt), 32'd15);
        end

        // asynchronous reset in the middle of a multiply
        cyc("rm1",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_MULS, 0, 1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        stall_m = 0;
        flush_m = 0;
        chk("arst/ctl", 32'(obs_s), 32'(C_RST));
        chk("arst/busy", 32'(busy), 32'd0);
        chk("arst/stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst/flush_cnt", 32'(flush_cnt), 32'd0);
        chk("arst/s_stall_cnt", 32'(s_stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mul = 1'b0;
        cyc("post",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
